// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed common-anode seven-segment driver with a double-buffered load path.
// Optional anti-ghosting blank window at the start of each slot: define SEVENSEG_GHOST_GUARD_EN.
module sevenseg_scan_driver #(
  parameter int unsigned SCAN_BITS  = 16,
  parameter int unsigned BLINK_BITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic        pending,
  output logic        frame,
  output logic [3:0]  DIGIT,
  output logic [7:0]  DISPLAY
);

  logic [15:0]           shadow_code_q, active_code_q;
  logic [3:0]            shadow_blank_q, shadow_blink_q, shadow_dp_q;
  logic [3:0]            active_blank_q, active_blink_q, active_dp_q;
  logic                  pending_q, frame_q;
  logic [SCAN_BITS-1:0]  scan_q;
  logic [BLINK_BITS-1:0] blink_q;
  logic [3:0]            digit_q, digit_d;
  logic [7:0]            display_q, display_d;

  logic       boundary;
  logic [1:0] slot;
  logic [3:0] code;
  logic       dark;

  function automatic logic [7:0] glyph(input logic [3:0] c);
    case (c)
      4'd0:    glyph = 8'b00000011;
      4'd1:    glyph = 8'b10011111;
      4'd2:    glyph = 8'b00100101;
      4'd3:    glyph = 8'b00001101;
      4'd4:    glyph = 8'b10011001;
      4'd5:    glyph = 8'b01001001;
      4'd6:    glyph = 8'b01000001;
      4'd7:    glyph = 8'b00011111;
      4'd8:    glyph = 8'b00000001;
      4'd9:    glyph = 8'b00001001;
      4'd10:   glyph = 8'b11111101;
      default: glyph = 8'hFF;
    endcase
  endfunction

  assign boundary = &scan_q;
  assign slot     = scan_q[SCAN_BITS-1 -: 2];
  assign code     = active_code_q[{slot, 2'b00} +: 4];
  assign dark     = active_blank_q[slot] | (active_blink_q[slot] & blink_q[BLINK_BITS-1]);

`ifdef SEVENSEG_GHOST_GUARD_EN
  localparam int unsigned SlotBits = SCAN_BITS - 2;
  localparam int unsigned GuardLen = (SCAN_BITS > 6) ? (1 << (SCAN_BITS - 6)) : 1;
  logic guard;
  assign guard = 32'(scan_q[SlotBits-1:0]) < GuardLen;
`endif

  always_comb begin
    digit_d   = ~(4'b0001 << slot);
    display_d = dark ? 8'hFF : glyph(code);
    if (!dark && active_dp_q[slot]) display_d[0] = 1'b0;
`ifdef SEVENSEG_GHOST_GUARD_EN
    if (guard) begin
      digit_d   = 4'b1111;
      display_d = 8'hFF;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q         <= '0;
      blink_q        <= '0;
      shadow_code_q  <= 16'hFFFF;
      shadow_blank_q <= 4'h0;
      shadow_blink_q <= 4'h0;
      shadow_dp_q    <= 4'h0;
      active_code_q  <= 16'hFFFF;
      active_blank_q <= 4'h0;
      active_blink_q <= 4'h0;
      active_dp_q    <= 4'h0;
      pending_q      <= 1'b0;
      frame_q        <= 1'b0;
      digit_q        <= 4'b1111;
      display_q      <= 8'hFF;
    end else begin
      scan_q  <= scan_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
      blink_q <= blink_q + {{(BLINK_BITS-1){1'b0}}, 1'b1};
      if (load) begin
        shadow_code_q  <= din;
        shadow_blank_q <= blank_mask;
        shadow_blink_q <= blink_mask;
        shadow_dp_q    <= dp_mask;
        // A load on the wrap edge bypasses the shadow so it is never a frame late.
        if (boundary) begin
          active_code_q  <= din;
          active_blank_q <= blank_mask;
          active_blink_q <= blink_mask;
          active_dp_q    <= dp_mask;
          pending_q      <= 1'b0;
        end else begin
          pending_q <= 1'b1;
        end
      end else if (boundary && pending_q) begin
        active_code_q  <= shadow_code_q;
        active_blank_q <= shadow_blank_q;
        active_blink_q <= shadow_blink_q;
        active_dp_q    <= shadow_dp_q;
        pending_q      <= 1'b0;
      end
      frame_q   <= boundary;
      digit_q   <= digit_d;
      display_q <= display_d;
    end
  end

  assign pending = pending_q;
  assign frame   = frame_q;
  assign DIGIT   = digit_q;
  assign DISPLAY = display_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver: a cycle-count reference model queues expected outputs,
// a monitor pops and compares them after every clock edge.
module tb_sevenseg_scan_driver;

  localparam int SB    = 4;
  localparam int BB    = 5;
  localparam int FRAME = 1 << SB;
  localparam int SLOT  = FRAME / 4;
  localparam int GUARD = (SB > 6) ? (1 << (SB - 6)) : 1;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] din;
  logic [3:0]  blank_mask, blink_mask, dp_mask;
  logic        pending, frame;
  logic [3:0]  DIGIT;
  logic [7:0]  DISPLAY;

  sevenseg_scan_driver #(
    .SCAN_BITS (SB),
    .BLINK_BITS(BB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .din       (din),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .dp_mask   (dp_mask),
    .pending   (pending),
    .frame     (frame),
    .DIGIT     (DIGIT),
    .DISPLAY   (DISPLAY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [13:0] exp_q[$];

  logic [7:0] glyphs [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  // Reference model: time is the number of edges since reset, display contents are plain arrays.
  int         cyc;
  logic [3:0] sh_c[4], ac_c[4];
  logic [3:0] sh_bk, sh_bl, sh_dp, ac_bk, ac_bl, ac_dp;
  bit         pend;
  bit         guard_en;

  task automatic model_reset();
    cyc = 0;
    pend = 0;
    for (int i = 0; i < 4; i++) begin
      sh_c[i] = 4'hF;
      ac_c[i] = 4'hF;
    end
    {sh_bk, sh_bl, sh_dp, ac_bk, ac_bl, ac_dp} = '0;
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] d,
                            input logic [3:0] bm, input logic [3:0] bl, input logic [3:0] dm);
    int scan, slot, off;
    bit phase, dark, bnd;
    logic [7:0] seg;
    logic [3:0] dig;
    scan  = cyc % FRAME;
    slot  = scan / SLOT;
    off   = scan % SLOT;
    phase = (cyc % (1 << BB)) >= (1 << (BB - 1));
    dark  = ac_bk[slot] || (ac_bl[slot] && phase);
    seg   = dark ? 8'hFF : glyphs[ac_c[slot]];
    if (!dark && ac_dp[slot]) seg[0] = 1'b0;
    dig = 4'b1111;
    dig[slot] = 1'b0;
    if (guard_en && off < GUARD) begin
      dig = 4'b1111;
      seg = 8'hFF;
    end
    bnd = (scan == FRAME - 1);
    if (ld) begin
      for (int i = 0; i < 4; i++) sh_c[i] = d[4*i +: 4];
      {sh_bk, sh_bl, sh_dp} = {bm, bl, dm};
      pend = !bnd;
      if (bnd) begin
        ac_c = sh_c;
        {ac_bk, ac_bl, ac_dp} = {sh_bk, sh_bl, sh_dp};
      end
    end else if (bnd && pend) begin
      ac_c = sh_c;
      {ac_bk, ac_bl, ac_dp} = {sh_bk, sh_bl, sh_dp};
      pend = 0;
    end
    exp_q.push_back({pend, bnd, dig, seg});
    cyc++;
  endtask

  task automatic step(input logic ld, input logic [15:0] d,
                      input logic [3:0] bm, input logic [3:0] bl, input logic [3:0] dm);
    @(negedge clk);
    rst_n = 1'b1;
    load = ld;
    din = d;
    blank_mask = bm;
    blink_mask = bl;
    dp_mask = dm;
    model_edge(ld, d, bm, bl, dm);
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic wait_phase(input int k);
    while (cyc % FRAME != k) idle();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    load = 1'b0;
    #1;
    vectors++;
    if ({pending, DIGIT, DISPLAY} !== {1'b0, 4'b1111, 8'hFF}) begin
      miscompares++;
      $display("FAIL async_reset: got pend=%b DIGIT=%b DISPLAY=%b want pend=0 DIGIT=1111 DISPLAY=11111111",
               pending, DIGIT, DISPLAY);
    end
    model_reset();
    exp_q.push_back({1'b0, 1'b0, 4'b1111, 8'hFF});
    repeat (n) begin
      @(negedge clk);
      exp_q.push_back({1'b0, 1'b0, 4'b1111, 8'hFF});
    end
  endtask

  // Monitor
  initial begin
    logic [13:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {pending, frame, DIGIT, DISPLAY};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL out t=%0t: got pend=%b frame=%b DIGIT=%b DISPLAY=%b want pend=%b frame=%b DIGIT=%b DISPLAY=%b",
                   $time, got[13], got[12], got[11:8], got[7:0], e[13], e[12], e[11:8], e[7:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    guard_en = 1'b0;
`ifdef SEVENSEG_GHOST_GUARD_EN
    guard_en = 1'b1;
`endif
    rst_n = 1'b0;
    load = 1'b0;
    din = '0;
    blank_mask = '0;
    blink_mask = '0;
    dp_mask = '0;
    model_reset();

    do_reset(3);
    repeat (20) idle();

    // Mid-frame load, committed at the next wrap.
    wait_phase(5);
    step(1'b1, 16'h5200, 4'h0, 4'h0, 4'h0);
    repeat (30) idle();

    // Two loads within one frame: the last one wins.
    wait_phase(2);
    step(1'b1, 16'h1111, 4'h0, 4'h0, 4'h0);
    wait_phase(7);
    step(1'b1, 16'h9999, 4'h0, 4'h0, 4'h0);
    repeat (30) idle();

    // Load on the wrap edge itself.
    wait_phase(FRAME - 1);
    step(1'b1, 16'h0A0A, 4'h0, 4'h0, 4'h0);
    repeat (20) idle();

    // Blink on digit0, decimal point on digit1.
    step(1'b1, 16'h4321, 4'h0, 4'b0001, 4'b0010);
    repeat (80) idle();

    // Asynchronous reset in slot 2 after a committed load.
    wait_phase(9);
    do_reset(2);
    repeat (20) idle();

    // Randomized loads, including blank masks and occasional wrap-edge hits.
    repeat (400) begin
      if ($urandom_range(0, 5) == 0)
        step(1'b1, 16'($urandom), 4'($urandom) & 4'($urandom), 4'($urandom), 4'($urandom));
      else
        idle();
    end

    // Another mid-run reset, then more random traffic.
    do_reset(1);
    repeat (100) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b1, 16'($urandom), 4'($urandom) & 4'($urandom), 4'($urandom), 4'($urandom));
      else
        idle();
    end

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
